attack_engine: RTL and testbench
================================

ATTACK_ENGINE -- requirements
Module: attack_engine

Interface
REQ-001 Parameter COORD_W, default 16, width of each X/Y coordinate and size field.
REQ-002 Parameter STARTUP_CYC, default 4, startup cycles before hitboxes go live.
REQ-003 Parameter LONG_CYC, default 16, active cycles for smash and special attacks; SHORT_CYC, default 8, active cycles for jabs.
REQ-004 Parameter RECOVER_CYC, default 6, lockout cycles after the active phase; SHIELD_CYC, default 32, shield hold limit; SHIELD_COOL_CYC, default 16, cycles after a shield ends before another shield may start.
REQ-005 clock  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 char1pos, char1size, char2pos, char2size  in  2*COORD_W each  {X,Y}; X in the upper half, unsigned, own character is char1.
REQ-008 controls  in  32  button word: [23:20] smash L/R/U/D, [16] A, [17] B, [19:18] shield, [15:13] stick X, [7:5] stick Y, [26] facing right.
REQ-009 opp_shield  in  1  opponent shield active.
REQ-010 attack  out  32  [0] hit landed this cycle, [4:1] attack ID, [6:5] phase, [7] any attack busy, [31:8] zero.
REQ-011 knockback  out  32  signed {X,Y} knockback, 16 bits each; movement  out  32  own-character displacement request; my_shield  out  1  shield up.

Function
REQ-012 Attack IDs: 0 none; 1-4 smash L/R/U/D; 5-6 jab L/R; 7-8 neutral special L/R; 9-12 special L/R/U/D. Stick "full" means all three bits 1 (right/up) or all three bits 0 (left/down).
REQ-013 Selection priority in IDLE: lowest ID among asserted requests wins; the rest are ignored.
REQ-014 Attack FSM states: IDLE(0), STARTUP(1), ACTIVE(2), RECOVER(3); encoding is visible on attack[6:5].
REQ-015 IDLE->STARTUP on a valid request with shield down; STARTUP->ACTIVE after STARTUP_CYC cycles; ACTIVE->RECOVER after LONG_CYC or SHORT_CYC cycles; RECOVER->IDLE after RECOVER_CYC cycles; inputs are ignored outside IDLE.
REQ-016 attack[4:1] holds the ID from STARTUP entry through the end of RECOVER, and is 0 in IDLE.
REQ-017 Hitboxes are each half the width and height of char1 and computed modulo 2^COORD_W. Origins: L=(x-w/2, y+h/4), R=(x+w, y+h/4), U=(x+w/4, y+h), D=(x+w/4, y-h/4). The hitbox used is the one matching the attack direction; neutral and jab attacks use L or R per facing.
REQ-018 Overlap is strict: ax<bx+bw and bx<ax+aw, and the same test on Y; edges that only touch do not overlap.
REQ-019 A hit is detected when the state is ACTIVE, the hitbox overlaps char2, opp_shield=0, and no hit has yet landed in this attack. attack[0] pulses for exactly one cycle, registered, one cycle after detection; at most one hit per attack.
REQ-020 knockback loads the table value for the current ID on the hit pulse cycle and holds it until the next hit or reset. movement is 0x00007F00 while special-U (ID 11) is ACTIVE and 0 otherwise.
REQ-021 Shield FSM: a shield request in attack IDLE with cooldown expired raises my_shield the next cycle. The shield drops on release or after SHIELD_CYC cycles, whichever is first, then enters SHIELD_COOL_CYC cooldown.
REQ-022 An attack request and a shield request in the same IDLE cycle: the shield wins and no attack starts.
REQ-023 All counters saturate and do not wrap; a parameter value of 0 is treated as 1.

Reset
REQ-024 Asserting reset at any time, including mid-attack or mid-shield, forces IDLE, clears the hit flag and all counters, and drives attack, knockback, movement and my_shield to 0 on the next output evaluation.

Configuration
REQ-025 With ATTACK_ENGINE_CHARGE_EN defined, holding the smash button during STARTUP extends STARTUP by up to CHARGE_CYC cycles (parameter, default 32). If the full charge is reached, knockback is doubled per axis with signed saturation to 16 bits.
REQ-026 Without ATTACK_ENGINE_CHARGE_EN, STARTUP is fixed at STARTUP_CYC, the charge logic is absent, and knockback is the table value.

Structure
REQ-027 The shared package attack_pkg holds the attack ID enum, the FSM state enum, the 13-entry knockback table (smash/special U 0x00000800, D 0x0000F7FE, L 0xF7FE00A0, R 0x080000A0; jab L 0xFFBE0010, R 0x00400010; neutral L 0xFBFE0080, R 0x04000080; ID 0 is 0), and the control bit-index constants.
REQ-028 The sub-module hitbox_overlap is purely combinational, takes (apos, asize, bpos, bsize), and outputs overlap; it is instantiated once per direction.

Verification
REQ-029 Smash-R, char1 (100,100) size (20,20), char2 (121,105) size (10,10) -> phase sequence 1,2,3,0 with lengths 4,16,6; exactly one attack[0] pulse; knockback=0x080000A0.
REQ-030 Same stimulus with char2 at X=130 (touching edge) -> no hit pulse; knockback is unchanged.
REQ-031 Smash-R and jab-R asserted together -> ID=2, not 6; opp_shield=1 throughout -> no hit.
REQ-032 Shield held 40 cycles -> my_shield high for 32 cycles; a request re-issued within 16 cycles is ignored; an attack plus shield in the same cycle -> shield only.
REQ-033 Reset asserted mid-ACTIVE -> all outputs 0 immediately, state IDLE; a new jab after release starts normally.
REQ-034 With CHARGE_EN defined, smash-U held 40 cycles in STARTUP -> STARTUP lasts 36 cycles; knockback=0x00001000 on hit.

Source files
------------

// File: rtl/attack_pkg.sv
// attack_pkg: attack IDs, FSM states, knockback table and control-word bit map shared by attack_engine
package attack_pkg;
  typedef enum logic [3:0] {
    ID_NONE, ID_SMASH_L, ID_SMASH_R, ID_SMASH_U, ID_SMASH_D, ID_JAB_L, ID_JAB_R,
    ID_NSP_L, ID_NSP_R, ID_SP_L, ID_SP_R, ID_SP_U, ID_SP_D
  } attack_id_e;
  typedef enum logic [1:0] {ST_IDLE, ST_STARTUP, ST_ACTIVE, ST_RECOVER} atk_state_e;
  typedef enum logic [1:0] {SH_READY, SH_UP, SH_COOL} shield_state_e;
  localparam int CTL_FACE_R  = 26;
  localparam int CTL_SMASH_L = 23;
  localparam int CTL_SMASH_R = 22;
  localparam int CTL_SMASH_U = 21;
  localparam int CTL_SMASH_D = 20;
  localparam int CTL_SHLD_HI = 19;
  localparam int CTL_SHLD_LO = 18;
  localparam int CTL_B       = 17;
  localparam int CTL_A       = 16;
  localparam int CTL_SX_HI   = 15;
  localparam int CTL_SX_LO   = 13;
  localparam int CTL_SY_HI   = 7;
  localparam int CTL_SY_LO   = 5;
  localparam logic [31:0] KB_TABLE [13] = '{
    32'h0000_0000,
    32'hF7FE_00A0, 32'h0800_00A0, 32'h0000_0800, 32'h0000_F7FE,
    32'hFFBE_0010, 32'h0040_0010,
    32'hFBFE_0080, 32'h0400_0080,
    32'hF7FE_00A0, 32'h0800_00A0, 32'h0000_0800, 32'h0000_F7FE
  };
  function automatic int min1(int v);
    return v < 1 ? 1 : v;
  endfunction
  // hitbox index: 0 L, 1 R, 2 U, 3 D
  function automatic logic [1:0] dir_of(attack_id_e id);
    return (id inside {ID_SMASH_R, ID_JAB_R, ID_NSP_R, ID_SP_R}) ? 2'd1 :
           (id inside {ID_SMASH_U, ID_SP_U}) ? 2'd2 :
           (id inside {ID_SMASH_D, ID_SP_D}) ? 2'd3 : 2'd0;
  endfunction
  function automatic logic [15:0] sat_double(logic [15:0] v);
    return (v[15] != v[14]) ? (v[15] ? 16'h8000 : 16'h7FFF) : {v[14:0], 1'b0};
  endfunction
endpackage

// File: rtl/attack_engine_if.sv
// attack_engine_if: character geometry, controls and attack/shield results of one fighter
interface attack_engine_if #(parameter int COORD_W = 16);
  logic [2*COORD_W-1:0] char1pos, char1size, char2pos, char2size;
  logic [31:0] controls;
  logic opp_shield;
  logic [31:0] attack, knockback, movement;
  logic my_shield;
  modport master (output char1pos, char1size, char2pos, char2size, controls, opp_shield,
                  input attack, knockback, movement, my_shield);
  modport slave (input char1pos, char1size, char2pos, char2size, controls, opp_shield,
                 output attack, knockback, movement, my_shield);
endinterface

// File: rtl/hitbox_overlap.sv
// hitbox_overlap: strict rectangle overlap of two {X,Y}-packed boxes; touching edges do not count
module hitbox_overlap #(parameter int COORD_W = 16) (
  input  logic [2*COORD_W-1:0] apos,
  input  logic [2*COORD_W-1:0] asize,
  input  logic [2*COORD_W-1:0] bpos,
  input  logic [2*COORD_W-1:0] bsize,
  output logic                 overlap
);
  localparam int E = COORD_W + 1;
  logic [COORD_W-1:0] ax, ay, aw, ah, bx, by, bw, bh;
  assign {ax, ay} = apos;
  assign {aw, ah} = asize;
  assign {bx, by} = bpos;
  assign {bw, bh} = bsize;
  // one extra bit keeps far edges from wrapping back below the near edge
  assign overlap = E'(ax) < E'(bx) + E'(bw) && E'(bx) < E'(ax) + E'(aw) &&
                   E'(ay) < E'(by) + E'(bh) && E'(by) < E'(ay) + E'(ah);
endmodule

// File: rtl/attack_engine.sv
// attack_engine: attack/shield sequencer with hit detection; ATTACK_ENGINE_CHARGE_EN enables smash charging
module attack_engine import attack_pkg::*; #(
  parameter int COORD_W         = 16,
  parameter int STARTUP_CYC     = 4,
  parameter int LONG_CYC        = 16,
  parameter int SHORT_CYC       = 8,
  parameter int RECOVER_CYC     = 6,
  parameter int SHIELD_CYC      = 32,
  parameter int SHIELD_COOL_CYC = 16
`ifdef ATTACK_ENGINE_CHARGE_EN
  , parameter int CHARGE_CYC    = 32
`endif
) (
  input logic clock,
  input logic reset,
  attack_engine_if.slave bus
);
  localparam logic [15:0] SU_M1  = 16'(min1(STARTUP_CYC) - 1);
  localparam logic [15:0] LG_M1  = 16'(min1(LONG_CYC) - 1);
  localparam logic [15:0] JB_M1  = 16'(min1(SHORT_CYC) - 1);
  localparam logic [15:0] RC_M1  = 16'(min1(RECOVER_CYC) - 1);
  localparam logic [15:0] SC_M1  = 16'(min1(SHIELD_CYC) - 1);
  localparam logic [15:0] SCC_M1 = 16'(min1(SHIELD_COOL_CYC) - 1);
  atk_state_e st_q, st_d;
  shield_state_e sh_q, sh_d;
  attack_id_e id_q, id_d, sel_id;
  logic [15:0] cnt_q, cnt_d, sh_cnt_q, sh_cnt_d;
  logic landed_q, landed_d, hit_q, hit_d;
  logic [31:0] kb_q, kb_d, kb_val, c;
  logic det, sreq, atk_go, sh_go, startup_done, act_done;
  logic xl, xr, yd, yu, nf, face, a, b;
  logic [12:1] req;
  logic [3:0] ov;
  logic [COORD_W-1:0] x, y, w, h;
  logic [2*COORD_W-1:0] hb_pos [4];
  logic [2*COORD_W-1:0] hb_size;
  logic unused_ctl;
  assign c = bus.controls;
  assign unused_ctl = ^{c[31:27], c[25:24], c[12:8], c[4:0]};
  assign {x, y} = bus.char1pos;
  assign {w, h} = bus.char1size;
  assign hb_size = {w >> 1, h >> 1};
  assign hb_pos[0] = {x - (w >> 1), y + (h >> 2)};
  assign hb_pos[1] = {x + w, y + (h >> 2)};
  assign hb_pos[2] = {x + (w >> 2), y + h};
  assign hb_pos[3] = {x + (w >> 2), y - (h >> 2)};
  for (genvar d = 0; d < 4; d++) begin : g_hb
    hitbox_overlap #(.COORD_W(COORD_W)) u_ov (
      .apos(hb_pos[d]), .asize(hb_size), .bpos(bus.char2pos), .bsize(bus.char2size), .overlap(ov[d])
    );
  end
  assign xr = &c[CTL_SX_HI:CTL_SX_LO];
  assign xl = ~|c[CTL_SX_HI:CTL_SX_LO];
  assign yu = &c[CTL_SY_HI:CTL_SY_LO];
  assign yd = ~|c[CTL_SY_HI:CTL_SY_LO];
  assign nf = !(xr || xl || yu || yd);
  assign face = c[CTL_FACE_R];
  assign a = c[CTL_A];
  assign b = c[CTL_B];
  assign req = {b & yd, b & yu, b & xr, b & xl, b & nf & face, b & nf & !face, a & face, a & !face,
                c[CTL_SMASH_D], c[CTL_SMASH_U], c[CTL_SMASH_R], c[CTL_SMASH_L]};
  always_comb begin
    sel_id = ID_NONE;
    for (int i = 12; i >= 1; i--) if (req[i]) sel_id = attack_id_e'(i[3:0]);
  end
  assign sreq = |c[CTL_SHLD_HI:CTL_SHLD_LO];
  assign atk_go = st_q == ST_IDLE && sh_q != SH_UP && !sreq && sel_id != ID_NONE;
  assign sh_go = st_q == ST_IDLE && sh_q == SH_READY && sreq;
  assign act_done = cnt_q >= ((id_q == ID_JAB_L || id_q == ID_JAB_R) ? JB_M1 : LG_M1);
  assign det = st_q == ST_ACTIVE && ov[dir_of(id_q)] && !bus.opp_shield && !landed_q;
`ifdef ATTACK_ENGINE_CHARGE_EN
  localparam logic [15:0] CH_M1 = 16'(min1(STARTUP_CYC) + min1(CHARGE_CYC) - 1);
  logic charged_q, charged_d, hold;
  assign hold = (id_q == ID_SMASH_L && c[CTL_SMASH_L]) || (id_q == ID_SMASH_R && c[CTL_SMASH_R]) ||
                (id_q == ID_SMASH_U && c[CTL_SMASH_U]) || (id_q == ID_SMASH_D && c[CTL_SMASH_D]);
  assign startup_done = cnt_q >= SU_M1 && (!hold || cnt_q >= CH_M1);
  assign charged_d = st_q == ST_STARTUP ? cnt_q >= CH_M1 : charged_q;
  assign kb_val = charged_q ? {sat_double(KB_TABLE[id_q][31:16]), sat_double(KB_TABLE[id_q][15:0])}
                            : KB_TABLE[id_q];
`else
  assign startup_done = cnt_q >= SU_M1;
  assign kb_val = KB_TABLE[id_q];
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      st_q <= ST_IDLE;
      sh_q <= SH_READY;
      id_q <= ID_NONE;
      cnt_q <= '0;
      sh_cnt_q <= '0;
      landed_q <= 1'b0;
      hit_q <= 1'b0;
      kb_q <= '0;
`ifdef ATTACK_ENGINE_CHARGE_EN
      charged_q <= 1'b0;
`endif
    end else begin
      st_q <= st_d;
      sh_q <= sh_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      sh_cnt_q <= sh_cnt_d;
      landed_q <= landed_d;
      hit_q <= hit_d;
      kb_q <= kb_d;
`ifdef ATTACK_ENGINE_CHARGE_EN
      charged_q <= charged_d;
`endif
    end
  always_comb begin
    st_d = st_q;
    id_d = id_q;
    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
    landed_d = landed_q | det;
    hit_d = det;
    kb_d = det ? kb_val : kb_q;
    sh_d = sh_q;
    sh_cnt_d = (sh_cnt_q == '1) ? sh_cnt_q : sh_cnt_q + 16'd1;
    case (st_q)
      ST_IDLE:    if (atk_go) begin st_d = ST_STARTUP; id_d = sel_id; cnt_d = '0; landed_d = 1'b0; end
      ST_STARTUP: if (startup_done) begin st_d = ST_ACTIVE; cnt_d = '0; end
      ST_ACTIVE:  if (act_done) begin st_d = ST_RECOVER; cnt_d = '0; end
      default:    if (cnt_q >= RC_M1) begin st_d = ST_IDLE; id_d = ID_NONE; cnt_d = '0; end
    endcase
    case (sh_q)
      SH_READY: if (sh_go) begin sh_d = SH_UP; sh_cnt_d = '0; end
      SH_UP:    if (!sreq || sh_cnt_q >= SC_M1) begin sh_d = SH_COOL; sh_cnt_d = '0; end
      SH_COOL:  if (sh_cnt_q >= SCC_M1) begin sh_d = SH_READY; sh_cnt_d = '0; end
      default:  sh_d = SH_READY;
    endcase
  end
  always_comb begin
    bus.attack = {24'd0, st_q != ST_IDLE, st_q, id_q, hit_q};
    bus.knockback = kb_q;
    bus.movement = (st_q == ST_ACTIVE && id_q == ID_SP_U) ? 32'h0000_7F00 : 32'd0;
    bus.my_shield = sh_q == SH_UP;
  end
endmodule

// File: tb/tb_attack_engine.sv
// tb_attack_engine: directed scenarios for attack_engine with hand-computed expectations
module tb_attack_engine;
  localparam logic [31:0] SM_R   = 32'h0040_0000;
  localparam logic [31:0] SM_U   = 32'h0020_0000;
  localparam logic [31:0] BTN_A  = 32'h0001_0000;
  localparam logic [31:0] BTN_B  = 32'h0002_0000;
  localparam logic [31:0] SHL    = 32'h0004_0000;
  localparam logic [31:0] SHH    = 32'h0008_0000;
  localparam logic [31:0] FACE_R = 32'h0400_0000;
  localparam logic [31:0] SX_MID = 32'h0000_6000;
  localparam logic [31:0] SY_MID = 32'h0000_0060;
  localparam logic [31:0] SY_UP  = 32'h0000_00E0;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int r_su, r_ac, r_rc, r_hits, r_mv;
  logic [3:0] r_id;
  logic r_seq, r_done;
  attack_engine_if #(.COORD_W(16)) bus();
  attack_engine dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end
  task automatic set_pos(input logic [15:0] c2x, input logic [15:0] c2y);
    bus.char1pos = {16'd100, 16'd100};
    bus.char1size = {16'd20, 16'd20};
    bus.char2pos = {c2x, c2y};
    bus.char2size = {16'd10, 16'd10};
  endtask
  task automatic run_attack(input logic [31:0] ctl, input int hold);
    logic [1:0] ph, prev;
    r_su = 0; r_ac = 0; r_rc = 0; r_hits = 0; r_mv = 0; r_id = 0; r_seq = 1; r_done = 0; prev = 0;
    bus.controls = ctl;
    for (int k = 0; k < 200 && !r_done; k++) begin
      @(negedge clock);
      if (k + 1 >= hold) bus.controls = 0;
      ph = bus.attack[6:5];
      if (ph == 2'd1 && r_su == 0) r_id = bus.attack[4:1];
      r_su += int'(ph == 2'd1);
      r_ac += int'(ph == 2'd2);
      r_rc += int'(ph == 2'd3);
      r_hits += int'(bus.attack[0]);
      r_mv += int'(bus.movement == 32'h0000_7F00);
      if (ph != prev && ph != prev + 2'd1) r_seq = 0;
      if (bus.attack[7] != (ph != 2'd0)) r_seq = 0;
      r_done = ph == 2'd0 && prev != 2'd0;
      prev = ph;
    end
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clock);
    checks++; if (bus.attack !== 32'd0) begin failures++; $display("FAIL reset_attack got=%h exp=0", bus.attack); end
    checks++; if (bus.knockback !== 32'd0) begin failures++; $display("FAIL reset_kb got=%h exp=0", bus.knockback); end
    checks++; if (bus.movement !== 32'd0) begin failures++; $display("FAIL reset_mv got=%h exp=0", bus.movement); end
    checks++; if (bus.my_shield !== 1'b0) begin failures++; $display("FAIL reset_shield got=%b exp=0", bus.my_shield); end
    reset = 1'b0;
    @(negedge clock);
  endtask
  task automatic test_smash_hit;
    set_pos(121, 105);
    run_attack(SM_R, 1);
    checks++; if (r_done !== 1'b1 || r_seq !== 1'b1) begin failures++; $display("FAIL smash_seq done=%b seq=%b exp 1 1", r_done, r_seq); end
    checks++; if (r_id !== 4'd2) begin failures++; $display("FAIL smash_id got=%0d exp=2", r_id); end
    checks++; if (r_su !== 4) begin failures++; $display("FAIL smash_startup got=%0d exp=4", r_su); end
    checks++; if (r_ac !== 16) begin failures++; $display("FAIL smash_active got=%0d exp=16", r_ac); end
    checks++; if (r_rc !== 6) begin failures++; $display("FAIL smash_recover got=%0d exp=6", r_rc); end
    checks++; if (r_hits !== 1) begin failures++; $display("FAIL smash_hits got=%0d exp=1", r_hits); end
    checks++; if (r_mv !== 0) begin failures++; $display("FAIL smash_mv got=%0d exp=0", r_mv); end
    checks++; if (bus.knockback !== 32'h0800_00A0) begin failures++; $display("FAIL smash_kb got=%h exp=080000a0", bus.knockback); end
  endtask
  task automatic test_jab;
    set_pos(85, 108);
    run_attack(BTN_A, 1);
    checks++; if (r_id !== 4'd5) begin failures++; $display("FAIL jab_id got=%0d exp=5", r_id); end
    checks++; if (r_ac !== 8) begin failures++; $display("FAIL jab_active got=%0d exp=8", r_ac); end
    checks++; if (r_hits !== 1) begin failures++; $display("FAIL jab_hits got=%0d exp=1", r_hits); end
    checks++; if (bus.knockback !== 32'hFFBE_0010) begin failures++; $display("FAIL jab_kb got=%h exp=ffbe0010", bus.knockback); end
  endtask
  task automatic test_touching;
    set_pos(130, 105);
    run_attack(SM_R, 1);
    checks++; if (r_done !== 1'b1 || r_id !== 4'd2) begin failures++; $display("FAIL touch_run done=%b id=%0d exp 1 2", r_done, r_id); end
    checks++; if (r_hits !== 0) begin failures++; $display("FAIL touch_hits got=%0d exp=0", r_hits); end
    checks++; if (bus.knockback !== 32'hFFBE_0010) begin failures++; $display("FAIL touch_kb got=%h exp=ffbe0010", bus.knockback); end
  endtask
  task automatic test_priority;
    set_pos(121, 105);
    bus.opp_shield = 1'b1;
    run_attack(SM_R | BTN_A | FACE_R, 1);
    bus.opp_shield = 1'b0;
    checks++; if (r_id !== 4'd2) begin failures++; $display("FAIL prio_id got=%0d exp=2", r_id); end
    checks++; if (r_ac !== 16) begin failures++; $display("FAIL prio_active got=%0d exp=16", r_ac); end
    checks++; if (r_hits !== 0) begin failures++; $display("FAIL prio_hits got=%0d exp=0", r_hits); end
    checks++; if (bus.knockback !== 32'hFFBE_0010) begin failures++; $display("FAIL prio_kb got=%h exp=ffbe0010", bus.knockback); end
  endtask
  task automatic test_neutral_special;
    set_pos(121, 105);
    run_attack(BTN_B | SX_MID | SY_MID | FACE_R, 1);
    checks++; if (r_id !== 4'd8) begin failures++; $display("FAIL nsp_id got=%0d exp=8", r_id); end
    checks++; if (r_ac !== 16 || r_hits !== 1) begin failures++; $display("FAIL nsp_run active=%0d hits=%0d exp 16 1", r_ac, r_hits); end
    checks++; if (bus.knockback !== 32'h0400_0080) begin failures++; $display("FAIL nsp_kb got=%h exp=04000080", bus.knockback); end
  endtask
  task automatic test_special_up;
    set_pos(108, 125);
    run_attack(BTN_B | SX_MID | SY_UP, 1);
    checks++; if (r_id !== 4'd11) begin failures++; $display("FAIL spu_id got=%0d exp=11", r_id); end
    checks++; if (r_mv !== 16) begin failures++; $display("FAIL spu_move_cycles got=%0d exp=16", r_mv); end
    checks++; if (r_hits !== 1) begin failures++; $display("FAIL spu_hits got=%0d exp=1", r_hits); end
    checks++; if (bus.knockback !== 32'h0000_0800) begin failures++; $display("FAIL spu_kb got=%h exp=00000800", bus.knockback); end
  endtask
  task automatic test_shield;
    int up, first, up2;
    up = 0; first = -1; up2 = 0;
    bus.controls = SHL;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (k == 38) bus.controls = 0;
      if (bus.my_shield) begin up++; if (first < 0) first = k; end
    end
    checks++; if (up !== 32) begin failures++; $display("FAIL shield_len got=%0d exp=32", up); end
    checks++; if (first !== 0) begin failures++; $display("FAIL shield_rise got=%0d exp=0", first); end
    bus.controls = SHH;
    repeat (4) begin @(negedge clock); up2 += int'(bus.my_shield); end
    bus.controls = 0;
    checks++; if (up2 !== 0) begin failures++; $display("FAIL shield_cooldown got=%0d exp=0", up2); end
    repeat (20) @(negedge clock);
    bus.controls = SHH | SM_R;
    @(negedge clock);
    checks++; if (bus.my_shield !== 1'b1) begin failures++; $display("FAIL shield_wins got=%b exp=1", bus.my_shield); end
    checks++; if (bus.attack !== 32'd0) begin failures++; $display("FAIL shield_noattack got=%h exp=0", bus.attack); end
    bus.controls = 0;
    @(negedge clock);
    checks++; if (bus.my_shield !== 1'b0 || bus.attack !== 32'd0) begin failures++; $display("FAIL shield_release shield=%b attack=%h exp 0 0", bus.my_shield, bus.attack); end
    repeat (20) @(negedge clock);
  endtask
  task automatic test_reset_mid;
    set_pos(500, 500);
    bus.controls = BTN_B | SX_MID | SY_UP;
    @(negedge clock);
    bus.controls = 0;
    repeat (6) @(negedge clock);
    checks++; if (bus.attack[6:5] !== 2'd2 || bus.movement !== 32'h0000_7F00) begin failures++; $display("FAIL rmid_pre phase=%0d mv=%h exp 2 00007f00", bus.attack[6:5], bus.movement); end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.attack !== 32'd0) begin failures++; $display("FAIL rmid_attack got=%h exp=0", bus.attack); end
    checks++; if (bus.knockback !== 32'd0) begin failures++; $display("FAIL rmid_kb got=%h exp=0", bus.knockback); end
    checks++; if (bus.movement !== 32'd0 || bus.my_shield !== 1'b0) begin failures++; $display("FAIL rmid_mv_shield mv=%h sh=%b exp 0 0", bus.movement, bus.my_shield); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    set_pos(121, 105);
    run_attack(BTN_A | FACE_R, 1);
    checks++; if (r_done !== 1'b1 || r_id !== 4'd6) begin failures++; $display("FAIL rmid_jab done=%b id=%0d exp 1 6", r_done, r_id); end
    checks++; if (r_su !== 4 || r_ac !== 8 || r_rc !== 6) begin failures++; $display("FAIL rmid_jab_len su=%0d ac=%0d rc=%0d exp 4 8 6", r_su, r_ac, r_rc); end
    checks++; if (r_hits !== 1 || bus.knockback !== 32'h0040_0010) begin failures++; $display("FAIL rmid_jab_hit hits=%0d kb=%h exp 1 00400010", r_hits, bus.knockback); end
  endtask
`ifdef ATTACK_ENGINE_CHARGE_EN
  task automatic test_charge;
    set_pos(108, 125);
    run_attack(SM_U, 40);
    checks++; if (r_id !== 4'd3) begin failures++; $display("FAIL charge_id got=%0d exp=3", r_id); end
    checks++; if (r_su !== 36) begin failures++; $display("FAIL charge_startup got=%0d exp=36", r_su); end
    checks++; if (r_hits !== 1 || bus.knockback !== 32'h0000_1000) begin failures++; $display("FAIL charge_kb hits=%0d kb=%h exp 1 00001000", r_hits, bus.knockback); end
  endtask
`endif
  initial begin
    bus.controls = 0;
    bus.opp_shield = 1'b0;
    set_pos(121, 105);
    test_reset();
    test_smash_hit();
    test_jab();
    test_touching();
    test_priority();
    test_neutral_special();
    test_special_up();
    test_shield();
    test_reset_mid();
`ifdef ATTACK_ENGINE_CHARGE_EN
    test_charge();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
